// File: rtl/fetch_sequencer.sv
// fetch_sequencer: self-timed PC / instruction-fetch FSM with memory handshake, branch load and timeout.
module fetch_sequencer #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int OPC_W    = 4,
  parameter int REG_W    = 5,
  parameter int PC_STEP  = 1,
  parameter int RESET_PC = 0,
  parameter int TIMEOUT  = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fetch_start,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_value,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_valid,
  output logic [ADDR_W-1:0] pc_out,
  output logic [DATA_W-1:0] midr_out,
  output logic [OPC_W-1:0]  ir_out,
  output logic [REG_W-1:0]  rg1_out,
  output logic [REG_W-1:0]  rg2_out,
  output logic              instr_valid,
  output logic              fetch_error,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, REQ, LATCH} state_t;
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_midr;
  logic [OPC_W-1:0]  r_ir;
  logic [REG_W-1:0]  r_rg1;
  logic [REG_W-1:0]  r_rg2;
  logic              r_mem_req;
  logic              r_instr_valid;
  logic              r_fetch_error;
  logic              r_busy;
  logic              w_timeout;
  // r_cnt counts completed REQ edges; the TIMEOUT-th one aborts unless mem_valid wins
  assign w_timeout   = (TIMEOUT > 0) && (r_cnt == CW'(TIMEOUT - 1));
  assign mem_req     = r_mem_req;
  assign mem_addr    = r_pc;
  assign pc_out      = r_pc;
  assign midr_out    = r_midr;
  assign ir_out      = r_ir;
  assign rg1_out     = r_rg1;
  assign rg2_out     = r_rg2;
  assign instr_valid = r_instr_valid;
  assign fetch_error = r_fetch_error;
  assign busy        = r_busy;
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_pc          <= ADDR_W'(RESET_PC);
      r_midr        <= '0;
      r_ir          <= '0;
      r_rg1         <= '0;
      r_rg2         <= '0;
      r_mem_req     <= 1'b0;
      r_instr_valid <= 1'b0;
      r_fetch_error <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_instr_valid <= 1'b0;
      r_fetch_error <= 1'b0;
      case (r_state)
        IDLE: begin
          if (pc_load) r_pc <= pc_load_value;
          if (fetch_start) begin
            r_state   <= REQ;
            r_cnt     <= '0;
            r_mem_req <= 1'b1;
            r_busy    <= 1'b1;
          end
        end
        REQ: begin
          if (mem_valid) begin
            r_midr    <= mem_rdata;
            r_state   <= LATCH;
            r_mem_req <= 1'b0;
          end else if (w_timeout) begin
            r_state       <= IDLE;
            r_mem_req     <= 1'b0;
            r_busy        <= 1'b0;
            r_fetch_error <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        LATCH: begin
          r_ir          <= r_midr[DATA_W-1 -: OPC_W];
          r_rg1         <= r_midr[DATA_W-OPC_W-1 -: REG_W];
          r_rg2         <= r_midr[DATA_W-OPC_W-REG_W-1 -: REG_W];
          r_pc          <= r_pc + ADDR_W'(PC_STEP);
          r_instr_valid <= 1'b1;
          r_state       <= IDLE;
          r_busy        <= 1'b0;
        end
        default: begin
          r_state   <= IDLE;
          r_mem_req <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: randomized fetch stimulus with a transaction-level model and pulse-driven scoreboard.
module tb_fetch_sequencer;
  localparam int TO = 15;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic fetch_start = 1'b0;
  logic pc_load = 1'b0;
  logic mem_valid = 1'b0;
  logic [15:0] pc_load_value = '0;
  logic [15:0] mem_rdata = '0;
  logic mem_req, instr_valid, fetch_error, busy;
  logic [15:0] mem_addr, pc_out, midr_out;
  logic [3:0] ir_out;
  logic [4:0] rg1_out, rg2_out;

  fetch_sequencer #(.TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .fetch_start(fetch_start), .pc_load(pc_load),
    .pc_load_value(pc_load_value), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid), .pc_out(pc_out), .midr_out(midr_out),
    .ir_out(ir_out), .rg1_out(rg1_out), .rg2_out(rg2_out), .instr_valid(instr_valid),
    .fetch_error(fetch_error), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          err;
    logic [15:0] pc;
    logic [15:0] midr;
    logic [3:0]  ir;
    logic [4:0]  rg1;
    logic [4:0]  rg2;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int passed = 0;
  logic [15:0] m_pc = '0;
  logic [15:0] m_midr = '0;
  logic [3:0]  m_ir = '0;
  logic [4:0]  m_rg1 = '0;
  logic [4:0]  m_rg2 = '0;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a === e) passed++;
    else $display("FAIL %s: got %0h expected %0h", n, a, e);
  endtask

  function automatic exp_t snap(input bit err);
    exp_t e;
    e.err = err; e.pc = m_pc; e.midr = m_midr; e.ir = m_ir; e.rg1 = m_rg1; e.rg2 = m_rg2;
    return e;
  endfunction

  exp_t got;
  always @(negedge clock) begin
    if (!reset && (instr_valid || fetch_error)) begin
      if (q.size() == 0) chk("unexpected_pulse", {30'd0, instr_valid, fetch_error}, 32'd0);
      else begin
        got = q.pop_front();
        chk("pulse_kind", {30'd0, instr_valid, fetch_error}, got.err ? 32'd1 : 32'd2);
        chk("sb_pc", pc_out, got.pc);
        chk("sb_midr", midr_out, got.midr);
        chk("sb_ir", ir_out, got.ir);
        chk("sb_rg1", rg1_out, got.rg1);
        chk("sb_rg2", rg2_out, got.rg2);
      end
    end
  end

  // Issues one fetch; wt wait cycles before mem_valid, wt>=TO means memory never answers.
  task automatic fetch(input bit ld, input logic [15:0] lv, input logic [15:0] w, input int wt, input bit ld_mid);
    logic [15:0] a;
    int n;
    a = ld ? lv : m_pc;
    fetch_start = 1'b1; pc_load = ld; pc_load_value = lv;
    @(posedge clock); #1;
    fetch_start = 1'b0; pc_load = 1'b0;
    m_pc = a;
    n = (wt >= TO) ? TO : wt;
    if (wt >= TO) q.push_back(snap(1'b1));
    for (int i = 0; i < n; i++) begin
      chk("req_hold", {30'd0, mem_req, busy}, 32'd3);
      chk("addr_hold", mem_addr, a);
      if (ld_mid && i == 0) begin pc_load = 1'b1; pc_load_value = 16'h1234; end
      @(posedge clock); #1;
      pc_load = 1'b0;
    end
    if (wt >= TO) begin
      chk("timeout_drop", {30'd0, mem_req, busy}, 32'd0);
      chk("timeout_err", fetch_error, 1'b1);
    end else begin
      chk("req_hold", {30'd0, mem_req, busy}, 32'd3);
      chk("addr_hold", mem_addr, a);
      mem_valid = 1'b1; mem_rdata = w;
      m_pc = a + 16'd1;
      m_midr = w;
      m_ir = 4'(w >> 12);
      m_rg1 = 5'((w >> 7) & 16'h1f);
      m_rg2 = 5'((w >> 2) & 16'h1f);
      q.push_back(snap(1'b0));
      @(posedge clock); #1;
      mem_valid = 1'b0; mem_rdata = 16'($urandom);
      chk("midr_latched", midr_out, w);
      chk("early_valid", instr_valid, 1'b0);
      chk("req_dropped", mem_req, 1'b0);
      @(posedge clock); #1;
      chk("latency_valid", instr_valid, 1'b1);
      chk("idle_busy", busy, 1'b0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clock);
    #1; reset = 1'b0;
    chk("rst_pc", pc_out, 16'h0);
    chk("rst_midr", midr_out, 16'h0);
    chk("rst_fields", {19'd0, ir_out, rg1_out, rg2_out}, 32'd0);
    chk("rst_flags", {28'd0, mem_req, busy, instr_valid, fetch_error}, 32'd0);

    fetch(1'b0, 16'h0, 16'hA5B4, 0, 1'b0);
    chk("zw_midr", midr_out, 16'hA5B4);
    chk("zw_ir", ir_out, 4'hA);
    chk("zw_rg1", rg1_out, 5'h0B);
    chk("zw_rg2", rg2_out, 5'h0D);
    chk("zw_pc", pc_out, 16'h1);
    for (int i = 0; i < 3; i++) fetch(1'b0, 16'h0, 16'($urandom), 0, 1'b0);
    chk("b2b_pc", pc_out, 16'h4);

    fetch(1'b0, 16'h0, 16'($urandom), 4, 1'b1);
    chk("wait_pc", pc_out, 16'h5);

    fetch(1'b1, 16'hFFFF, 16'($urandom), 0, 1'b0);
    chk("wrap_pc", pc_out, 16'h0);

    fetch(1'b0, 16'h0, 16'h0, TO, 1'b0);
    mem_valid = 1'b1; mem_rdata = 16'hBEEF;
    @(posedge clock); #1;
    mem_valid = 1'b0;
    @(posedge clock); #1;
    chk("late_valid_ignored", {30'd0, instr_valid, busy}, 32'd0);
    chk("to_pc_kept", pc_out, m_pc);
    chk("to_ir_kept", ir_out, m_ir);

    fetch(1'b0, 16'h0, 16'($urandom), TO - 1, 1'b0);

    fetch_start = 1'b1;
    @(posedge clock); #1;
    fetch_start = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    m_pc = '0; m_midr = '0; m_ir = '0; m_rg1 = '0; m_rg2 = '0;
    chk("midrst_flags", {30'd0, mem_req, busy}, 32'd0);
    chk("midrst_pc", pc_out, 16'h0);
    chk("midrst_midr", midr_out, 16'h0);
    mem_valid = 1'b1; mem_rdata = 16'h1357;
    @(posedge clock); #1;
    mem_valid = 1'b0;
    @(posedge clock); #1;
    chk("midrst_no_valid", {30'd0, instr_valid, busy}, 32'd0);

    for (int k = 0; k < 40; k++) begin
      bit ld;
      int wt;
      ld = ($urandom_range(0, 3) == 0);
      wt = ($urandom_range(0, 9) == 0) ? int'($urandom_range(TO - 1, TO + 1)) : int'($urandom_range(0, 5));
      fetch(ld, 16'($urandom), 16'($urandom), wt, (wt > 0) && ($urandom_range(0, 1) == 1));
    end
    repeat (3) @(posedge clock);
    #1;
    chk("queue_empty", q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
